// File: rtl/sat_node_stack.sv
// rtl/sat_node_stack.sv - DPLL-style SAT search node with a decision stack and fork/abort messaging
module sat_node_stack #(
   parameter int VAR_W       = 8,
   parameter int K           = 3,
   parameter int NUM_CLAUSES = 16,
   parameter int NUM_VARS    = 16,
   parameter int STACK_DEPTH = 16,
   localparam int CW = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1,
   localparam int DW = $clog2(STACK_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_msg_type,
   input  logic [VAR_W-1:0] in_var,
   input  logic [K-1:0]     in_mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_msg_type,
   output logic [VAR_W-1:0] out_var,
   output logic [K-1:0]     out_mask,
   input  logic             peer_idle,
   output logic [VAR_W-1:0] cur_var,
   output logic             cur_pol,
   output logic [CW-1:0]    clause_idx,
   output logic [DW-1:0]    depth,
   output logic             node_busy,
   output logic             sat_found,
   output logic             unsat_found,
   output logic             overflow
);

   localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [1:0] MSG_NONE  = 2'b00;
   localparam logic [1:0] MSG_FORK  = 2'b01;
   localparam logic [1:0] MSG_SUB   = 2'b10;
   localparam logic [1:0] MSG_ABORT = 2'b11;

   typedef enum logic [2:0] {IDLE, EVAL, DECIDE, OFFER, BACKTRACK, DONE} state_t;

   state_t                 state;
   logic [VAR_W-1:0]       var_stk [STACK_DEPTH];
   logic [STACK_DEPTH-1:0] pol_stk;
   logic [STACK_DEPTH-1:0] bd_stk;

   logic [DW-1:0]    depth_m1;
   logic [SW-1:0]    top_idx;
   logic [SW-1:0]    push_idx;
   logic             top_bd;
   logic             in_fire;
   logic             abort_acc;
   logic             last_var;
   logic             full;
   logic             push_en;
   logic             push_pol;
   logic             push_bd;
   logic [VAR_W-1:0] push_var;
   logic [K-1:0]     offer_mask;

   assign depth_m1 = depth - DW'(1);
   assign top_idx  = depth_m1[SW-1:0];
   assign push_idx = depth[SW-1:0];

   // Empty stack reads as zero so the status outputs match their reset values.
   assign cur_var = (depth == '0) ? '0 : var_stk[top_idx];
   assign cur_pol = (depth != '0) && pol_stk[top_idx];
   assign top_bd  = (depth != '0) && bd_stk[top_idx];

   assign in_ready  = (state == IDLE) || (state == EVAL) || (in_msg_type == MSG_ABORT);
   assign in_fire   = in_valid && in_ready;
   assign abort_acc = in_valid && (in_msg_type == MSG_ABORT);
   assign node_busy = (state != IDLE) && (state != DONE);
   assign last_var  = (cur_var == VAR_W'(NUM_VARS - 1));
   assign full      = (depth == DW'(STACK_DEPTH));

   always_comb begin
      offer_mask    = '0;
      offer_mask[0] = ~cur_pol;
      offer_mask[1] = 1'b1;
   end

   // All pushes share one write port; the source decides var/pol/both_done.
   always_comb begin
      push_en  = 1'b0;
      push_var = cur_var + VAR_W'(1);
      push_pol = 1'b0;
      push_bd  = 1'b0;
      if (!abort_acc) begin
         case (state)
            IDLE: begin
               if (in_fire && (in_msg_type == MSG_FORK)) begin
                  push_en  = 1'b1;
                  push_var = in_var;
                  push_pol = in_mask[0];
                  push_bd  = in_mask[1];
               end
            end
            DECIDE:  push_en = !last_var && !peer_idle;
            OFFER:   push_en = out_ready;
            default: push_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         depth        <= '0;
         clause_idx   <= '0;
         out_valid    <= 1'b0;
         out_msg_type <= MSG_NONE;
         out_var      <= '0;
         out_mask     <= '0;
         sat_found    <= 1'b0;
         unsat_found  <= 1'b0;
         overflow     <= 1'b0;
      end else if (abort_acc) begin
         state        <= IDLE;
         depth        <= '0;
         clause_idx   <= '0;
         out_valid    <= 1'b0;
         out_msg_type <= MSG_NONE;
         sat_found    <= 1'b0;
         unsat_found  <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         case (state)
            EVAL: begin
               if (in_fire && (in_msg_type == MSG_SUB)) begin
                  if (&in_mask) begin
                     state <= BACKTRACK;
                  end else if (clause_idx == CW'(NUM_CLAUSES - 1)) begin
                     clause_idx <= '0;
                     state      <= DECIDE;
                  end else begin
                     clause_idx <= clause_idx + CW'(1);
                  end
               end
            end
            DECIDE: begin
               if (last_var) begin
                  sat_found <= 1'b1;
                  state     <= DONE;
               end else if (peer_idle) begin
                  // Hand the opposite polarity to the neighbour; this branch is then fully owned.
                  state            <= OFFER;
                  out_valid        <= 1'b1;
                  out_msg_type     <= MSG_FORK;
                  out_var          <= cur_var;
                  out_mask         <= offer_mask;
                  bd_stk[top_idx]  <= 1'b1;
               end
            end
            OFFER: begin
               if (out_ready) begin
                  out_valid    <= 1'b0;
                  out_msg_type <= MSG_NONE;
               end
            end
            BACKTRACK: begin
               if (depth == '0) begin
                  unsat_found <= 1'b1;
                  state       <= DONE;
               end else if (top_bd) begin
                  depth <= depth_m1;
                  if (depth == DW'(1)) begin
                     unsat_found <= 1'b1;
                     state       <= DONE;
                  end
               end else begin
                  pol_stk[top_idx] <= ~pol_stk[top_idx];
                  bd_stk[top_idx]  <= 1'b1;
                  clause_idx       <= '0;
                  state            <= EVAL;
               end
            end
            default: ;
         endcase

         if (push_en) begin
            if (full) begin
               overflow <= 1'b1;
               state    <= DONE;
            end else begin
               var_stk[push_idx] <= push_var;
               pol_stk[push_idx] <= push_pol;
               bd_stk[push_idx]  <= push_bd;
               depth             <= depth + DW'(1);
               clause_idx        <= '0;
               state             <= EVAL;
            end
         end
      end
   end

endmodule

// File: tb/tb_sat_node_stack.sv
// tb/tb_sat_node_stack.sv - scoreboard bench for sat_node_stack
module tb_sat_node_stack;

   localparam logic [1:0] M_NONE  = 2'b00;
   localparam logic [1:0] M_FORK  = 2'b01;
   localparam logic [1:0] M_SUB   = 2'b10;
   localparam logic [1:0] M_ABORT = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       in_valid, in_ready, out_valid, out_ready, peer_idle, cur_pol;
   logic [1:0] in_msg_type, out_msg_type;
   logic [7:0] in_var, out_var, cur_var;
   logic [2:0] in_mask, out_mask;
   logic [3:0] clause_idx;
   logic [4:0] depth;
   logic       node_busy, sat_found, unsat_found, overflow;

   logic       o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_peer_idle, o_cur_pol;
   logic [1:0] o_in_msg_type, o_out_msg_type;
   logic [7:0] o_in_var, o_out_var, o_cur_var;
   logic [2:0] o_in_mask, o_out_mask;
   logic [3:0] o_clause_idx;
   logic [2:0] o_depth;
   logic       o_node_busy, o_sat_found, o_unsat_found, o_overflow;

   sat_node_stack dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_msg_type(in_msg_type),
      .in_var(in_var), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_msg_type(out_msg_type),
      .out_var(out_var), .out_mask(out_mask),
      .peer_idle(peer_idle), .cur_var(cur_var), .cur_pol(cur_pol),
      .clause_idx(clause_idx), .depth(depth), .node_busy(node_busy),
      .sat_found(sat_found), .unsat_found(unsat_found), .overflow(overflow)
   );

   sat_node_stack #(.NUM_VARS(20), .STACK_DEPTH(4)) u_ovf (
      .clk(clk), .rst_n(rst_n),
      .in_valid(o_in_valid), .in_ready(o_in_ready), .in_msg_type(o_in_msg_type),
      .in_var(o_in_var), .in_mask(o_in_mask),
      .out_valid(o_out_valid), .out_ready(o_out_ready), .out_msg_type(o_out_msg_type),
      .out_var(o_out_var), .out_mask(o_out_mask),
      .peer_idle(o_peer_idle), .cur_var(o_cur_var), .cur_pol(o_cur_pol),
      .clause_idx(o_clause_idx), .depth(o_depth), .node_busy(o_node_busy),
      .sat_found(o_sat_found), .unsat_found(o_unsat_found), .overflow(o_overflow)
   );

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [1:0] t;
      logic [7:0] v;
      logic [2:0] m;
   } msg_t;
   msg_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input bit ovf, input logic [1:0] t, input logic [7:0] v, input logic [2:0] m);
      int  n;
      logic rdy;
      if (!ovf) begin
         in_valid = 1'b1; in_msg_type = t; in_var = v; in_mask = m;
      end else begin
         o_in_valid = 1'b1; o_in_msg_type = t; o_in_var = v; o_in_mask = m;
      end
      n = 0;
      forever begin
         @(negedge clk);
         rdy = ovf ? o_in_ready : in_ready;
         if (rdy) break;
         n++;
         if (n > 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for type %0d", t);
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!ovf) in_valid = 1'b0;
      else      o_in_valid = 1'b0;
   endtask

   task automatic sweep(input bit ovf, input int n);
      repeat (n) send(ovf, M_SUB, 8'd0, 3'b001);
   endtask

   // Out-port monitor: holds stability while stalled and pops expectations on each transfer.
   msg_t prev_out;
   logic held = 1'b0;
   always @(negedge clk) begin
      msg_t e;
      if (rst_n && out_valid) begin
         if (held) begin
            checks++;
            if ({out_msg_type, out_var, out_mask} !== prev_out) begin
               failures++;
               $display("FAIL out_hold: got %h expected %h", {out_msg_type, out_var, out_mask}, prev_out);
            end
         end
         if (out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL out_unexpected: got %h expected none", {out_msg_type, out_var, out_mask});
            end else begin
               e = exp_q.pop_front();
               if ({out_msg_type, out_var, out_mask} !== e) begin
                  failures++;
                  $display("FAIL out_msg: got %h expected %h", {out_msg_type, out_var, out_mask}, e);
               end
            end
            held = 1'b0;
         end else begin
            held = 1'b1;
            prev_out = {out_msg_type, out_var, out_mask};
         end
      end else begin
         held = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_msg_type = M_NONE; in_var = '0; in_mask = '0;
      out_ready = 1'b0; peer_idle = 1'b0;
      o_in_valid = 1'b0; o_in_msg_type = M_NONE; o_in_var = '0; o_in_mask = '0;
      o_out_ready = 1'b1; o_peer_idle = 1'b0;
      cyc(3);
      chk("rst_depth", depth, 0);
      chk("rst_clause", clause_idx, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_type", out_msg_type, 0);
      chk("rst_out_var", out_var, 0);
      chk("rst_out_mask", out_mask, 0);
      chk("rst_cur_var", cur_var, 0);
      chk("rst_cur_pol", cur_pol, 0);
      chk("rst_flags", {sat_found, unsat_found, overflow, node_busy}, 0);
      chk("rst_ovf_depth", o_depth, 0);
      rst_n = 1'b1;
      cyc(1);

      // Walk to the last variable: two pushes then sat.
      send(0, M_FORK, 8'd14, 3'b001);
      chk("fork_depth", depth, 1);
      chk("fork_var", cur_var, 14);
      chk("fork_pol", cur_pol, 1);
      chk("fork_busy", node_busy, 1);
      sweep(0, 16);
      cyc(1);
      chk("push_depth", depth, 2);
      chk("push_var", cur_var, 15);
      chk("push_pol", cur_pol, 0);
      chk("push_clause", clause_idx, 0);
      sweep(0, 16);
      cyc(1);
      chk("sat_found", sat_found, 1);
      chk("sat_depth", depth, 2);
      chk("sat_busy", node_busy, 0);
      chk("sat_unsat", unsat_found, 0);
      in_valid = 1'b1; in_msg_type = M_FORK; in_var = 8'd1; in_mask = 3'b000;
      @(negedge clk);
      chk("done_not_ready", in_ready, 0);
      cyc(2);
      in_valid = 1'b0;
      chk("sat_sticky", sat_found, 1);
      chk("done_depth_kept", depth, 2);
      send(0, M_ABORT, 8'd0, 3'b000);
      chk("abort_depth", depth, 0);
      chk("abort_sat", sat_found, 0);
      chk("abort_busy", node_busy, 0);

      // Conflict at clause 5 flips the decision.
      send(0, M_FORK, 8'd3, 3'b000);
      sweep(0, 5);
      chk("clause5", clause_idx, 5);
      send(0, M_SUB, 8'd0, 3'b111);
      chk("bt_busy", node_busy, 1);
      cyc(1);
      chk("flip_pol", cur_pol, 1);
      chk("flip_clause", clause_idx, 0);
      chk("flip_depth", depth, 1);
      chk("flip_var", cur_var, 3);
      send(0, M_FORK, 8'd9, 3'b000);
      chk("eval_fork_discard", depth, 1);
      send(0, M_NONE, 8'd0, 3'b111);
      chk("none_discard", clause_idx, 0);
      sweep(0, 1);
      chk("clause1", clause_idx, 1);
      send(0, M_SUB, 8'd0, 3'b111);
      cyc(1);
      chk("bt2_unsat", unsat_found, 1);
      chk("bt2_depth", depth, 0);
      send(0, M_ABORT, 8'd0, 3'b000);

      // Both-done entry pops straight to unsat.
      send(0, M_FORK, 8'd2, 3'b010);
      send(0, M_SUB, 8'd0, 3'b111);
      cyc(1);
      chk("pop_depth", depth, 0);
      chk("pop_unsat", unsat_found, 1);
      chk("pop_busy", node_busy, 0);
      send(0, M_ABORT, 8'd0, 3'b000);
      chk("abort_unsat", unsat_found, 0);

      // Abort in EVAL at clause 7.
      send(0, M_FORK, 8'd5, 3'b000);
      sweep(0, 7);
      chk("clause7", clause_idx, 7);
      send(0, M_ABORT, 8'd0, 3'b000);
      chk("eval_abort_depth", depth, 0);
      chk("eval_abort_busy", node_busy, 0);
      chk("eval_abort_clause", clause_idx, 0);
      send(0, M_SUB, 8'd0, 3'b111);
      chk("idle_sub_discard", {node_busy, depth}, 0);

      // Offer to an idle peer with a 3-cycle stall.
      peer_idle = 1'b1;
      exp_q.push_back({M_FORK, 8'd9, 3'b011});
      send(0, M_FORK, 8'd9, 3'b000);
      sweep(0, 16);
      cyc(1);
      chk("offer_valid", out_valid, 1);
      cyc(3);
      chk("offer_no_push", depth, 1);
      out_ready = 1'b1;
      cyc(1);
      out_ready = 1'b0;
      peer_idle = 1'b0;
      chk("offer_drop", out_valid, 0);
      chk("offer_push_depth", depth, 2);
      chk("offer_push_var", cur_var, 10);
      chk("offer_push_pol", cur_pol, 0);
      send(0, M_SUB, 8'd0, 3'b111);
      cyc(1);
      chk("offer_flip_pol", cur_pol, 1);
      send(0, M_SUB, 8'd0, 3'b111);
      cyc(2);
      chk("offered_entry_popped", depth, 0);
      chk("offered_unsat", unsat_found, 1);
      send(0, M_ABORT, 8'd0, 3'b000);

      // Reset while an offer is pending.
      peer_idle = 1'b1;
      send(0, M_FORK, 8'd4, 3'b000);
      sweep(0, 16);
      cyc(1);
      chk("offer2_valid", out_valid, 1);
      chk("offer2_var", out_var, 4);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      peer_idle = 1'b0;
      chk("rst_offer_valid", out_valid, 0);
      chk("rst_offer_type", out_msg_type, 0);
      chk("rst_offer_depth", depth, 0);
      chk("rst_offer_busy", node_busy, 0);

      // Overflow on the fifth push with a 4-deep stack.
      send(1, M_FORK, 8'd0, 3'b000);
      repeat (4) sweep(1, 16);
      cyc(1);
      chk("ovf_flag", o_overflow, 1);
      chk("ovf_depth", o_depth, 4);
      chk("ovf_top_var", o_cur_var, 3);
      chk("ovf_busy", o_node_busy, 0);
      chk("ovf_sat", o_sat_found, 0);
      chk("ovf_no_out", o_out_valid, 0);
      send(1, M_ABORT, 8'd0, 3'b000);
      chk("ovf_abort", {o_overflow, o_depth}, 0);

      chk("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sat_node_stack.md
SAT_NODE_STACK -- requirements
Module: sat_node_stack

Interface
REQ-001 SHALL have parameter VAR_W, default 8: variable-id width.
REQ-002 SHALL have parameter K, default 3, minimum 2: literals per clause and mask width.
REQ-003 SHALL have parameter NUM_CLAUSES, default 16: clause masks per evaluation sweep.
REQ-004 SHALL have parameter NUM_VARS, default 16: the last variable id is NUM_VARS-1.
REQ-005 SHALL have parameter STACK_DEPTH, default 16: decision-stack entries.
REQ-006 SHALL have one clock and a synchronous active-low reset: clk input 1, clock; rst_n input 1, reset.
REQ-007 SHALL have these message inputs:
- in_valid input 1: message present.
- in_ready output 1: node accepts the message.
- in_msg_type input 2: message type.
- in_var input VAR_W: variable id.
- in_mask input K: falsified-literal mask or fork flags.
REQ-008 SHALL have these message outputs:
- out_valid output 1: message offered.
- out_ready input 1: peer accepts the message.
- out_msg_type output 2: message type.
- out_var output VAR_W: variable id.
- out_mask output K: fork flags.
REQ-009 SHALL have these control and status ports:
- peer_idle input 1: a neighbour can take a branch.
- cur_var output VAR_W: top-of-stack variable.
- cur_pol output 1: top-of-stack polarity.
- clause_idx output clog2(NUM_CLAUSES): next clause expected.
- depth output clog2(STACK_DEPTH+1): stack occupancy.
- node_busy, sat_found, unsat_found, overflow: outputs, 1 bit each.

Function
REQ-010 SHALL use these message encodings: NONE=00, FORK=01, SUBSTITUTION_MASK=10, ABORT=11.
REQ-011 SHALL treat a message as transferred when valid&ready are both high on a rising clk edge; out_* SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-012 SHALL use states IDLE, EVAL, DECIDE, OFFER, BACKTRACK, DONE; in_ready=1 in IDLE and EVAL, and in any state when in_msg_type=ABORT.
REQ-013 SHALL store per stack entry: var, pol, both_done.
REQ-014 SHALL handle FORK accepted in IDLE as follows: push {in_var, pol=in_mask[0], both_done=in_mask[1]}, clause_idx=0, go to EVAL next cycle.
REQ-015 SHALL, in EVAL, take each accepted SUBSTITUTION_MASK as the mask for clause clause_idx; mask all-ones means conflict and causes a transition to BACKTRACK.
REQ-016 SHALL, in EVAL, advance clause_idx by 1 on a non-conflict mask; the mask at clause_idx=NUM_CLAUSES-1 moves to DECIDE and wraps clause_idx to 0.
REQ-017 SHALL, in DECIDE, go to DONE with sat_found=1 if top var = NUM_VARS-1.
REQ-018 SHALL, in DECIDE, otherwise go to OFFER if peer_idle=1, else push {var+1, 0, 0} and go to EVAL.
REQ-019 SHALL, in OFFER, drive out_valid=1, out_msg_type=FORK, out_var=top var, out_mask[0]=~top pol, out_mask[1]=1, other bits 0, and set top both_done=1.
REQ-020 SHALL, on the OFFER handshake, push {var+1, 0, 0} and go to EVAL.
REQ-021 SHALL, in BACKTRACK, pop one entry per cycle while top both_done=1.
REQ-022 SHALL, in BACKTRACK, go to DONE with unsat_found=1 when the stack becomes empty.
REQ-023 SHALL, in BACKTRACK, otherwise flip top pol, set both_done=1, set clause_idx=0 and go to EVAL.
REQ-024 SHALL, on a push with depth=STACK_DEPTH, set overflow=1 and go to DONE without writing the stack.
REQ-025 SHALL, on ABORT accepted in any state, clear the stack, clause_idx, sat_found, unsat_found and overflow, drop out_valid, and go to IDLE next cycle.
REQ-026 SHALL consume and discard wrong-type messages: SUBSTITUTION_MASK in IDLE, FORK in EVAL, and NONE in any state.
REQ-027 SHALL drive node_busy=1 in every state except IDLE and DONE.
REQ-028 SHALL leave DONE only by ABORT or reset; sat_found, unsat_found and overflow are sticky in DONE.
REQ-029 SHALL apply a simultaneous ABORT and mask or handshake with ABORT winning.

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, enter IDLE with these values:
- Registers: depth=0, clause_idx=0, out_valid=0, out_msg_type=NONE, out_var=0, out_mask=0, cur_var=0, cur_pol=0.
- Flags: sat_found=0, unsat_found=0, overflow=0, node_busy=0.
REQ-031 SHALL apply reset mid-operation, including during OFFER, on the next edge, dropping any pending out message.

Verification
REQ-032 SHALL cover: FORK var=14, mask=001, then 16 masks of 001 with peer_idle=0 -> push var 15, then 16 more masks -> sat_found=1, depth=2.
REQ-033 SHALL cover: FORK var=3, mask=000, then a mask of 111 at clause 5 -> BACKTRACK, then cur_pol=1 and clause_idx=0.
REQ-034 SHALL cover: FORK mask=010 and a conflict at clause 0 -> one pop, depth=0, unsat_found=1.
REQ-035 SHALL cover: a clean sweep with peer_idle=1 and out_ready held 0 for 3 cycles -> out FORK var=top, mask=011 held stable, then push after the handshake.
REQ-036 SHALL cover: NUM_VARS=20, STACK_DEPTH=4, starting at var 0 with clean sweeps -> overflow=1 on the fifth push, depth=4.
REQ-037 SHALL cover: ABORT in EVAL at clause 7 -> IDLE, depth=0, node_busy=0 next cycle.
